// File: rtl/maxnet_pkg.sv
// Shared types and constants for the 4-neuron Maxnet block.
// Used by the controller, weight buffer and datapath.
package maxnet_pkg;

    localparam int N            = 4;
    localparam int MAX_ITER_DEF = 15;

    localparam logic [4:0] OWN_WEIGHT     = 5'b01000;
    localparam logic [4:0] DEFAULT_WEIGHT = 5'b11110;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_ITER,
        S_DONE
    } state_t;

endpackage

// File: rtl/maxnet_controller_survivor_encoder.sv
// Counts surviving neurons and encodes the index
// of the survivor when exactly one remains.
module survivor_encoder
    import maxnet_pkg::*;
(
    input  logic [N-1:0] act_nonzero,
    output logic         one_left,
    output logic         none_left,
    output logic [1:0]   idx
);

    logic [2:0] cnt;

    // Popcount plus index of the highest set flag
    always_comb begin
        cnt = '0;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (act_nonzero[i]) begin
                cnt = cnt + 3'd1;
                idx = 2'(i);
            end
        end
    end

    assign one_left  = (cnt == 3'd1);
    assign none_left = (cnt == 3'd0);

endmodule

// File: rtl/maxnet_controller.sv
// Run sequencer for the Maxnet datapath: load,
// iterate until one survivor, collapse or limit.
module maxnet_controller
    import maxnet_pkg::*;
#(
    parameter int MAX_ITER = MAX_ITER_DEF,
    parameter int CW       = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  act_nonzero,
    output logic          ld_in,
    output logic          iter_en,
    output logic          busy,
    output logic          done,
    output logic [1:0]    winner,
    output logic          winner_valid,
    output logic          timeout,
    output logic [CW-1:0] iter_count
);

    state_t     state;
    logic       one_left;
    logic       none_left;
    logic [1:0] idx;
    logic       at_limit;

    survivor_encoder u_enc (
        .act_nonzero (act_nonzero),
        .one_left    (one_left),
        .none_left   (none_left),
        .idx         (idx)
    );

    assign at_limit = (iter_count == CW'(MAX_ITER));

    // Sequencer with registered strobes and result holds
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            ld_in        <= 1'b0;
            iter_en      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            winner       <= '0;
            winner_valid <= 1'b0;
            timeout      <= 1'b0;
            iter_count   <= '0;
        end else begin
            ld_in   <= 1'b0;
            iter_en <= 1'b0;
            done    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state        <= S_LOAD;
                        ld_in        <= 1'b1;
                        busy         <= 1'b1;
                        iter_count   <= '0;
                        winner       <= '0;
                        winner_valid <= 1'b0;
                        timeout      <= 1'b0;
                    end
                end
                S_LOAD: begin
                    state <= S_CHECK;
                end
                S_CHECK: begin
                    if (one_left) begin
                        state        <= S_DONE;
                        done         <= 1'b1;
                        winner       <= idx;
                        winner_valid <= 1'b1;
                    end else if (none_left) begin
                        state        <= S_DONE;
                        done         <= 1'b1;
                        winner_valid <= 1'b0;
                        timeout      <= 1'b0;
                    end else if (at_limit) begin
                        state        <= S_DONE;
                        done         <= 1'b1;
                        winner_valid <= 1'b0;
                        timeout      <= 1'b1;
                    end else begin
                        state      <= S_ITER;
                        iter_en    <= 1'b1;
                        iter_count <= iter_count + CW'(1);
                    end
                end
                S_ITER: begin
                    state <= S_CHECK;
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
